// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the register-address tracking slice that
//   feeds the pipeline hazard unit.
//
//   REG_W        : register-number width
//   PC_REG       : architectural number of the program counter (r15)
//   stage_addr_t : per-stage address record {valid, ra1, ra2, wa3, wr, pcsrc}
//   pass_down    : forms the record loaded into the next stage. The source
//                  fields are cleared because only E compares its sources.
//                  wr/pcsrc are gated by the condition outcome of the stage
//                  being left.
package hazard_pkg;

  localparam int REG_W = 4;

  localparam logic [REG_W-1:0] PC_REG = 4'hF;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] ra1;
    logic [REG_W-1:0] ra2;
    logic [REG_W-1:0] wa3;
    logic             wr;
    logic             pcsrc;
  } stage_addr_t;

  // A failed condition suppresses the write side effects. The instruction
  // itself stays valid so that the valid chain keeps following the datapath.
  function automatic stage_addr_t pass_down(input stage_addr_t s,
                                            input logic        cond);
    stage_addr_t r;
    r       = s;
    r.ra1   = '0;
    r.ra2   = '0;
    r.wr    = s.wr & cond;
    r.pcsrc = s.pcsrc & cond;
    return r;
  endfunction

endpackage : hazard_pkg

// File: rtl/hazard_match_if.sv
// hazard_match_if
//   Bundle between the decode-stage datapath / hazard unit (master) and the
//   hazard_match block (slave).
//
//   master drives : ValidD, RA1D, RA2D, WA3D, RegWriteD, PCSrcD, CondExE,
//                   StallD, FlushE
//   slave drives  : Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
//                   Match_12D_E, PCWrPendingF, PCSrcW
interface hazard_match_if #(
  parameter int REG_W = hazard_pkg::REG_W
);

  // Decode-stage instruction fields
  logic             ValidD;
  logic [REG_W-1:0] RA1D;
  logic [REG_W-1:0] RA2D;
  logic [REG_W-1:0] WA3D;
  logic             RegWriteD;
  logic             PCSrcD;

  // Execute-stage condition result and hazard-unit controls
  logic             CondExE;
  logic             StallD;
  logic             FlushE;

  // Match terms returned to the hazard unit
  logic             Match_1E_M;
  logic             Match_1E_W;
  logic             Match_2E_M;
  logic             Match_2E_W;
  logic             Match_12D_E;
  logic             PCWrPendingF;
  logic             PCSrcW;

  modport master (
    output ValidD, RA1D, RA2D, WA3D, RegWriteD, PCSrcD,
    output CondExE, StallD, FlushE,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
    input  Match_12D_E, PCWrPendingF, PCSrcW
  );

  modport slave (
    input  ValidD, RA1D, RA2D, WA3D, RegWriteD, PCSrcD,
    input  CondExE, StallD, FlushE,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
    output Match_12D_E, PCWrPendingF, PCSrcW
  );

endinterface : hazard_match_if

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg
//   One pipeline stage of register-address state (a stage_addr_t record).
//   A flush loads an all-zero bubble. Reset does the same and always wins.
//
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the stage
//   flush : load a bubble instead of d
//   d     : record from the previous stage
//   q     : registered record
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  stage_addr_t d,
  output stage_addr_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : hazard_stage_reg

// File: rtl/hazard_match.sv
// hazard_match
//   Tracks the decode-stage source/destination register numbers and the
//   PC-write flag through the E, M and W stages. Compares them every cycle
//   to produce the match inputs of the hazard unit. All outputs are
//   combinational from the stage registers and the live D-stage inputs.
//
//   Parameters:
//     REG_W : register-number width (must equal hazard_pkg::REG_W)
//
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high; discards every in-flight stage
//     hm    : hazard_match_if.slave (D-stage fields, CondExE, StallD,
//             FlushE in; Match_*, PCWrPendingF, PCSrcW out)
//
//   Build option:
//     HAZARD_MATCH_R15_EXCL_EN : when defined, a source register equal to
//       r15 never matches. The datapath supplies PC+8 for r15 reads, so
//       these reads are never forwarded. PCWrPendingF is unaffected.
module hazard_match #(
  parameter int REG_W = hazard_pkg::REG_W
) (
  input  logic           clk,
  input  logic           reset,
  hazard_match_if.slave  hm
);

  import hazard_pkg::*;

  // Source/destination comparison shared by every match term.
  function automatic logic src_eq(input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] dst);
`ifdef HAZARD_MATCH_R15_EXCL_EN
    return (src == dst) && (src != PC_REG);
`else
    return (src == dst);
`endif
  endfunction

  stage_addr_t d_p0, st_p0;
  stage_addr_t d_p1, st_p1;
  stage_addr_t d_p2, st_p2;

  logic vld_p0, vld_p1, vld_p2;

  // ---- D -> E (p0): loads every cycle unless flushed ----
  // StallD does not hold E. The hazard unit pairs every load-use stall
  // with FlushE, and a stall without a flush loads E just as the datapath
  // does.
  assign d_p0 = '{valid: hm.ValidD,
                  ra1:   hm.RA1D,
                  ra2:   hm.RA2D,
                  wa3:   hm.WA3D,
                  wr:    hm.RegWriteD,
                  pcsrc: hm.PCSrcD};

  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .reset (reset),
    .flush (hm.FlushE),
    .d     (d_p0),
    .q     (st_p0)
  );

  assign vld_p0 = st_p0.valid;

  // ---- E -> M (p1): condition outcome applied on the way out of E ----
  assign d_p1 = pass_down(st_p0, hm.CondExE);

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (d_p1),
    .q     (st_p1)
  );

  assign vld_p1 = st_p1.valid;

  // ---- M -> W (p2): straight copy ----
  assign d_p2 = pass_down(st_p1, 1'b1);

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (d_p2),
    .q     (st_p2)
  );

  assign vld_p2 = st_p2.valid;

  // W source fields are always zero. StallD is accepted only to keep the
  // interface symmetric with the datapath.
  logic unused_bits;
  assign unused_bits = ^{st_p2.ra1, st_p2.ra2, hm.StallD};

  // ---- match generation (combinational) ----
  // Every term is qualified by the valid bits of both stages. A bubble
  // therefore never matches, even though its zero WA3 would compare equal
  // to a real r0 source.
  assign hm.Match_1E_M = vld_p0 & vld_p1 & st_p1.wr & src_eq(st_p0.ra1, st_p1.wa3);
  assign hm.Match_2E_M = vld_p0 & vld_p1 & st_p1.wr & src_eq(st_p0.ra2, st_p1.wa3);
  assign hm.Match_1E_W = vld_p0 & vld_p2 & st_p2.wr & src_eq(st_p0.ra1, st_p2.wa3);
  assign hm.Match_2E_W = vld_p0 & vld_p2 & st_p2.wr & src_eq(st_p0.ra2, st_p2.wa3);

  assign hm.Match_12D_E = hm.ValidD & vld_p0 & st_p0.wr &
                          (src_eq(hm.RA1D, st_p0.wa3) | src_eq(hm.RA2D, st_p0.wa3));

  assign hm.PCWrPendingF = (hm.ValidD & hm.PCSrcD) |
                           (vld_p0 & st_p0.pcsrc)  |
                           (vld_p1 & st_p1.pcsrc);

  assign hm.PCSrcW = vld_p2 & st_p2.pcsrc;

endmodule : hazard_match

// File: tb/tb_hazard_match.sv
// tb_hazard_match
//   Directed, table-driven bench for hazard_match. Each table row holds the
//   D-stage inputs for one cycle and the outputs required just before the
//   clock edge that registers those inputs. Expected bit order:
//   {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
//    PCWrPendingF, PCSrcW}.
module tb_hazard_match;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_match_if #(.REG_W(4)) hm();

  hazard_match #(.REG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hm    (hm)
  );

`ifdef HAZARD_MATCH_R15_EXCL_EN
  localparam logic R15M = 1'b0;
`else
  localparam logic R15M = 1'b1;
`endif

  typedef struct {
    logic       chk;
    logic       rst;
    logic       vld;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       wr;
    logic       pc;
    logic       cond;
    logic       stall;
    logic       flush;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic chk, input logic rst, input logic vld,
                     input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic [3:0] wa3, input logic wr, input logic pc,
                     input logic cond, input logic stall, input logic flush,
                     input logic [6:0] exp);
    vec_t v;
    v.chk = chk; v.rst = rst; v.vld = vld; v.ra1 = ra1; v.ra2 = ra2;
    v.wa3 = wa3; v.wr = wr; v.pc = pc; v.cond = cond; v.stall = stall;
    v.flush = flush; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    hm.ValidD    = v.vld;
    hm.RA1D      = v.ra1;
    hm.RA2D      = v.ra2;
    hm.WA3D      = v.wa3;
    hm.RegWriteD = v.wr;
    hm.PCSrcD    = v.pc;
    hm.CondExE   = v.cond;
    hm.StallD    = v.stall;
    hm.FlushE    = v.flush;
  endtask

  task automatic check(input string name, input int row,
                       input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic [6:0] e);
    check("Match_1E_M",   row, hm.Match_1E_M,   e[6]);
    check("Match_1E_W",   row, hm.Match_1E_W,   e[5]);
    check("Match_2E_M",   row, hm.Match_2E_M,   e[4]);
    check("Match_2E_W",   row, hm.Match_2E_W,   e[3]);
    check("Match_12D_E",  row, hm.Match_12D_E,  e[2]);
    check("PCWrPendingF", row, hm.PCWrPendingF, e[1]);
    check("PCSrcW",       row, hm.PCSrcW,       e[0]);
  endtask

  initial begin
    //   chk rst vld ra1 ra2 wa3 wr pc cnd stl fl  expected
    add(0, 1, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 0  reset
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 1  reset state
    add(1, 0, 1,  0, 0,  3, 1, 0, 1, 0, 0, 7'b0000000); // 2  ALU P: r3
    add(1, 0, 1,  3, 0,  4, 0, 0, 1, 0, 0, 7'b0000100); // 3  D uses r3
    add(1, 0, 1,  3, 3,  5, 0, 0, 1, 0, 0, 7'b1000000); // 4  E/M on r3
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0101000); // 5  both srcs vs W
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 6
    add(1, 0, 1,  0, 0,  5, 1, 0, 1, 0, 0, 7'b0000000); // 7  load r5
    add(1, 0, 1,  5, 0,  6, 1, 0, 1, 1, 1, 7'b0000100); // 8  stall+flush
    add(1, 0, 1,  5, 0,  6, 1, 0, 1, 0, 0, 7'b0000000); // 9  E bubble
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0100000); // 10 load in W
    add(1, 0, 1,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 11 r0 reader
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 12 vs bubble
    add(1, 0, 1,  0, 0,  2, 1, 0, 1, 0, 0, 7'b0000000); // 13 write r2
    add(1, 0, 1,  2, 0,  8, 0, 0, 0, 0, 0, 7'b0000100); // 14 cond fails
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 15 no M match
    add(1, 0, 0,  0, 0,  7, 1, 1, 1, 0, 0, 7'b0000000); // 16 invalid wr r7
    add(1, 0, 1,  7, 7,  0, 0, 0, 1, 0, 0, 7'b0000000); // 17
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 18 invalid in M
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 19 invalid in W
    add(1, 0, 1,  0, 0, 15, 1, 1, 1, 0, 0, 7'b0000010); // 20 PC write D
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000010); // 21 in E
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000010); // 22 in M
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000001); // 23 in W
    add(1, 0, 1,  0, 0, 15, 1, 1, 1, 0, 0, 7'b0000010); // 24 PC write D
    add(1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 7'b0000010); // 25 cond fails
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 26 M suppressed
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000000); // 27 W suppressed
    add(1, 0, 1,  0, 0, 15, 1, 0, 1, 0, 0, 7'b0000000); // 28 write r15
    add(1, 0, 1,  0, 0, 15, 1, 0, 1, 0, 0, 7'b0000000); // 29 write r15
    add(1, 0, 1, 15, 9,  0, 0, 0, 1, 0, 0, {4'b0000, R15M, 2'b00});     // 30
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, {R15M, R15M, 5'b00000});     // 31
    add(1, 0, 1,  0, 0,  9, 1, 0, 1, 0, 0, 7'b0000000); // 32 write r9
    add(1, 0, 1,  0, 0,  9, 1, 0, 1, 0, 0, 7'b0000000); // 33 write r9
    add(1, 0, 1,  1, 9,  1, 1, 0, 1, 0, 0, 7'b0000100); // 34 D ra2 r9
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0011000); // 35 M and W
    add(1, 0, 1,  0, 0,  1, 1, 0, 1, 0, 0, 7'b0000000); // 36 W0
    add(1, 0, 1,  0, 0,  1, 1, 1, 1, 0, 0, 7'b0000010); // 37 W1 (pc)
    add(1, 0, 1,  1, 0,  1, 1, 0, 1, 0, 0, 7'b0000110); // 38 W2
    add(1, 1, 1,  1, 1,  2, 1, 0, 1, 1, 1, 7'b1100110); // 39 reset edge
    add(1, 0, 1,  1, 1,  3, 1, 1, 1, 0, 0, 7'b0000010); // 40 after reset
    add(1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 7'b0000010); // 41

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) check_all(i, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // StallD without FlushE still loads E: a write to r4 issued under a
    // lone stall must be seen by the next D instruction and later in M.
    reset = 1'b0; hm.ValidD = 1'b1; hm.RA1D = 4'd0; hm.RA2D = 4'd0;
    hm.WA3D = 4'd4; hm.RegWriteD = 1'b1; hm.PCSrcD = 1'b0;
    hm.CondExE = 1'b1; hm.StallD = 1'b1; hm.FlushE = 1'b0;
    @(negedge clk);
    check("stall_only_pcpend", 100, hm.PCWrPendingF, 1'b1);
    @(posedge clk); #1;
    hm.RA2D = 4'd4; hm.WA3D = 4'd0; hm.RegWriteD = 1'b0; hm.StallD = 1'b0;
    @(negedge clk);
    check("stall_only_12D_E", 101, hm.Match_12D_E, 1'b1);
    check("stall_only_PCSrcW", 101, hm.PCSrcW, 1'b1);
    @(posedge clk); #1;
    hm.ValidD = 1'b0; hm.RA2D = 4'd0;
    @(negedge clk);
    check("stall_only_2E_M", 102, hm.Match_2E_M, 1'b1);
    check("stall_only_2E_W", 102, hm.Match_2E_W, 1'b0);
    check("stall_only_PCSrcW_clr", 102, hm.PCSrcW, 1'b0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_match
